// File: rtl/regfile_pkg.sv
// Shared types and helpers for the scoreboarded register file.
// Build option: REGFILE_BYPASS_EN selects same-cycle write-to-read forwarding in regfile_sb.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // Widest write-port count / address width the hit helper is sized for
    localparam int RF_MAX_WR = 8;
    localparam int RF_MAX_AW = 8;
    localparam int RF_PORT_W = $clog2(RF_MAX_WR);

    typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;

    typedef struct packed {
        logic                 hit;
        logic [RF_PORT_W-1:0] port;
    } wr_hit_t;

    // Ascending scan so the highest-numbered matching port is the one reported
    function automatic wr_hit_t rf_wr_hit(
        input logic [RF_MAX_WR-1:0]           we,
        input logic [RF_MAX_WR*RF_MAX_AW-1:0] waddr,
        input logic [RF_MAX_AW-1:0]           addr
    );
        wr_hit_t r;
        r = '0;
        for (int p = 0; p < RF_MAX_WR; p++) begin
            if (we[p] && (addr != '0) && (waddr[p*RF_MAX_AW +: RF_MAX_AW] == addr)) begin
                r.hit  = 1'b1;
                r.port = RF_PORT_W'(p);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an outstanding producer, gates
// issue on WAW hazards and keeps a registered population count of busy bits.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS = NREGS_DEF,
    parameter  int NWR   = 2,
    localparam int AW    = $clog2(NREGS),
    localparam int CW    = $clog2(NREGS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] waddr,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_rd,
    output logic              issue_ready,
    output logic [NREGS-1:0]  busy,
    output logic [CW-1:0]     pending_count
);

    logic [NREGS-1:0] busy_reg;
    logic [NREGS-1:0] busy_next;
    logic [NREGS-1:0] clr_vec;
    logic [NREGS-1:0] set_vec;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             rd_wr_hit;
    logic             ready_c;

    always_comb begin
        clr_vec   = '0;
        rd_wr_hit = 1'b0;
        for (int p = 0; p < NWR; p++) begin
            if (we[p] && (waddr[p*AW +: AW] != '0)) begin
                clr_vec[waddr[p*AW +: AW]] = 1'b1;
                if (waddr[p*AW +: AW] == issue_rd) begin
                    rd_wr_hit = 1'b1;
                end
            end
        end

        // A write retiring the current producer frees the slot for the new one
        ready_c = (issue_rd == '0) || !busy_reg[issue_rd] || rd_wr_hit;

        set_vec = '0;
        if (issue_valid && ready_c && (issue_rd != '0)) begin
            set_vec[issue_rd] = 1'b1;
        end

        // Set is OR-ed after the clear so the newly issued producer keeps ownership
        busy_next = (busy_reg & ~clr_vec) | set_vec;

        count_next = '0;
        for (int i = 0; i < NREGS; i++) begin
            count_next = count_next + CW'(busy_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_reg  <= '0;
            count_reg <= '0;
        end else begin
            busy_reg  <= busy_next;
            count_reg <= count_next;
        end
    end

    assign issue_ready   = ready_c;
    assign busy          = busy_reg;
    assign pending_count = count_reg;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with NRD combinational reads, NWR prioritised writes and a busy scoreboard.
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NREGS = NREGS_DEF,
    parameter  int NRD   = 2,
    parameter  int NWR   = 2,
    localparam int AW    = $clog2(NREGS),
    localparam int CW    = $clog2(NREGS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    output logic                issue_ready,
    output logic [CW-1:0]       pending_count
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;

    // Later ports are visited last, so their non-blocking assignment wins on a collision
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (we[p] && (waddr[p*AW +: AW] != '0)) begin
                    regs[waddr[p*AW +: AW]] <= wdata[p*XLEN +: XLEN];
                end
            end
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .we            (we),
        .waddr         (waddr),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_ready   (issue_ready),
        .busy          (busy),
        .pending_count (pending_count)
    );

`ifdef REGFILE_BYPASS_EN
    logic [RF_MAX_WR-1:0]           we_ext;
    logic [RF_MAX_WR*RF_MAX_AW-1:0] waddr_ext;

    assign we_ext = RF_MAX_WR'(we);

    for (genvar gi = 0; gi < RF_MAX_WR; gi++) begin : g_wext
        if (gi < NWR) begin : g_used
            assign waddr_ext[gi*RF_MAX_AW +: RF_MAX_AW] = RF_MAX_AW'(waddr[gi*AW +: AW]);
        end else begin : g_pad
            assign waddr_ext[gi*RF_MAX_AW +: RF_MAX_AW] = '0;
        end
    end
`endif

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = raddr[gi*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        wr_hit_t hit;
        assign hit = rf_wr_hit(we_ext, waddr_ext, RF_MAX_AW'(ra));
        assign rdata[gi*XLEN +: XLEN] = hit.hit ? wdata[hit.port*XLEN +: XLEN] : regs[ra];
        assign rbusy[gi]              = hit.hit ? 1'b0 : busy[ra];
`else
        assign rdata[gi*XLEN +: XLEN] = regs[ra];
        assign rbusy[gi]              = busy[ra];
`endif
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: reset, directed table, multi-cycle fill/drain and random vs. a spec model.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;
    localparam int CW    = 6;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                clk;
    logic                rst_n;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic                issue_valid;
    logic [AW-1:0]       issue_rd;
    logic                issue_ready;
    logic [CW-1:0]       pending_count;

    logic [AW-1:0]   ra [NRD];
    logic [AW-1:0]   wa [NWR];
    logic [XLEN-1:0] wd [NWR];

    assign raddr = {ra[1], ra[0]};
    assign waddr = {wa[1], wa[0]};
    assign wdata = {wd[1], wd[0]};

    regfile_sb #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .raddr         (raddr),
        .rdata         (rdata),
        .rbusy         (rbusy),
        .we            (we),
        .waddr         (waddr),
        .wdata         (wdata),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_ready   (issue_ready),
        .pending_count (pending_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: plain arrays updated by the spec's rules
    logic [XLEN-1:0]  m_regs [NREGS];
    logic [NREGS-1:0] m_busy;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [XLEN-1:0] exp_rdata(input int i);
        logic [XLEN-1:0] v;
        v = m_regs[ra[i]];
        if (BYP) begin
            for (int p = 0; p < NWR; p++) begin
                if (we[p] && wa[p] == ra[i] && ra[i] != 0) v = wd[p];
            end
        end
        return v;
    endfunction

    function automatic logic exp_rbusy(input int i);
        logic b;
        b = (ra[i] == 0) ? 1'b0 : m_busy[ra[i]];
        if (BYP) begin
            for (int p = 0; p < NWR; p++) begin
                if (we[p] && wa[p] == ra[i] && ra[i] != 0) b = 1'b0;
            end
        end
        return b;
    endfunction

    function automatic logic exp_ready();
        logic r;
        r = (issue_rd == 0) || !m_busy[issue_rd];
        for (int p = 0; p < NWR; p++) begin
            if (we[p] && wa[p] == issue_rd) r = 1'b1;
        end
        return r;
    endfunction

    task automatic model_update();
        logic rdy;
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
            m_busy = '0;
        end else begin
            rdy = exp_ready();
            for (int p = 0; p < NWR; p++) begin
                if (we[p] && wa[p] != 0) begin
                    m_regs[wa[p]] = wd[p];
                    m_busy[wa[p]] = 1'b0;
                end
            end
            if (issue_valid && rdy && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
    endtask

    task automatic set_idle();
        we          = '0;
        wa[0]       = '0;
        wa[1]       = '0;
        wd[0]       = '0;
        wd[1]       = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        ra[0]       = '0;
        ra[1]       = '0;
    endtask

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  ra0, ra1;
        logic [31:0] e_rd0, e_rd1;
        logic [1:0]  e_rb;
        logic        e_rdy;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t tbl [13];

    initial begin
        // x0 handling, write priority, WAW scoreboard, bypass/visibility, cleanup
        tbl[0]  = '{2'b01, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b1, 6'd0};
        tbl[1]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b1, 6'd0};
        tbl[2]  = '{2'b11, 5'd7, 5'd7, 32'h11, 32'h22, 1'b0, 5'd0, 5'd7, 5'd0,
                    BYP ? 32'h22 : 32'h0, 32'h0, 2'b00, 1'b1, 6'd0};
        tbl[3]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0, 32'h22, 32'h0, 2'b00, 1'b1, 6'd0};
        tbl[4]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0, 32'h0, 32'h0, 2'b00, 1'b1, 6'd0};
        tbl[5]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0, 32'h0, 32'h0, 2'b01, 1'b0, 6'd1};
        tbl[6]  = '{2'b01, 5'd3, 5'd0, 32'h55, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0,
                    BYP ? 32'h55 : 32'h0, 32'h0, BYP ? 2'b00 : 2'b01, 1'b1, 6'd1};
        tbl[7]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd3, 5'd3, 5'd0, 32'h55, 32'h0, 2'b01, 1'b0, 6'd1};
        tbl[8]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd9, 32'h0, 32'h0, 2'b00, 1'b1, 6'd1};
        tbl[9]  = '{2'b10, 5'd0, 5'd9, 32'h0, 32'hABCD, 1'b0, 5'd0, 5'd0, 5'd9,
                    32'h0, BYP ? 32'hABCD : 32'h0, BYP ? 2'b00 : 2'b10, 1'b1, 6'd2};
        tbl[10] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9, 32'h0, 32'hABCD, 2'b00, 1'b1, 6'd1};
        tbl[11] = '{2'b01, 5'd3, 5'd0, 32'h77, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0,
                    BYP ? 32'h77 : 32'h55, 32'h0, BYP ? 2'b00 : 2'b01, 1'b1, 6'd1};
        tbl[12] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd9, 32'h77, 32'hABCD, 2'b00, 1'b1, 6'd0};

        set_idle();
        rst_n = 1'b0;
        tick();
        tick();

        // Reset sequence: populate state, then reset with a write and issue pending
        @(negedge clk);
        rst_n       = 1'b1;
        we          = 2'b01;
        wa[0]       = 5'd5;
        wd[0]       = 32'hDEAD;
        issue_valid = 1'b1;
        issue_rd    = 5'd6;
        tick();
        @(negedge clk);
        set_idle();
        ra[0] = 5'd5;
        ra[1] = 5'd6;
        #1;
        chk("rst_pre_x5", 64'(rdata[31:0]), 64'h0000_DEAD);
        chk("rst_pre_busy", 64'(rbusy), 64'b10);
        chk("rst_pre_count", 64'(pending_count), 64'd1);
        $display("reset-prep: x5=%h rbusy=%b count=%0d", rdata[31:0], rbusy, pending_count);
        rst_n       = 1'b0;
        we          = 2'b01;
        wa[0]       = 5'd8;
        wd[0]       = 32'h1234;
        issue_valid = 1'b1;
        issue_rd    = 5'd8;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        set_idle();
        ra[0] = 5'd5;
        ra[1] = 5'd6;
        #1;
        chk("rst_x5", 64'(rdata[31:0]), 64'h0);
        chk("rst_x6", 64'(rdata[63:32]), 64'h0);
        chk("rst_busy", 64'(rbusy), 64'h0);
        chk("rst_count", 64'(pending_count), 64'h0);
        $display("reset: rdata=%h rbusy=%b count=%0d", rdata, rbusy, pending_count);
        tick();
        @(negedge clk);
        ra[0] = 5'd8;
        #1;
        chk("rst_drop_x8", 64'(rdata[31:0]), 64'h0);
        chk("rst_drop_busy", 64'(rbusy), 64'h0);
        tick();

        foreach (tbl[i]) begin
            @(negedge clk);
            we          = tbl[i].we;
            wa[0]       = tbl[i].wa0;
            wa[1]       = tbl[i].wa1;
            wd[0]       = tbl[i].wd0;
            wd[1]       = tbl[i].wd1;
            issue_valid = tbl[i].iv;
            issue_rd    = tbl[i].ird;
            ra[0]       = tbl[i].ra0;
            ra[1]       = tbl[i].ra1;
            #1;
            chk($sformatf("row%0d_rdata0", i), 64'(rdata[31:0]), 64'(tbl[i].e_rd0));
            chk($sformatf("row%0d_rdata1", i), 64'(rdata[63:32]), 64'(tbl[i].e_rd1));
            chk($sformatf("row%0d_rbusy", i), 64'(rbusy), 64'(tbl[i].e_rb));
            chk($sformatf("row%0d_ready", i), 64'(issue_ready), 64'(tbl[i].e_rdy));
            chk($sformatf("row%0d_count", i), 64'(pending_count), 64'(tbl[i].e_cnt));
            $display("row %0d: rdata0=%h rdata1=%h rbusy=%b ready=%b count=%0d",
                     i, rdata[31:0], rdata[63:32], rbusy, issue_ready, pending_count);
            tick();
        end

        // Fill every non-zero register, then drain two per cycle
        for (int r = 1; r < NREGS; r++) begin
            @(negedge clk);
            set_idle();
            issue_valid = 1'b1;
            issue_rd    = AW'(r);
            #1;
            chk($sformatf("fill%0d_ready", r), 64'(issue_ready), 64'h1);
            chk($sformatf("fill%0d_count", r), 64'(pending_count), 64'(r - 1));
            $display("fill x%0d: ready=%b count=%0d", r, issue_ready, pending_count);
            tick();
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            set_idle();
            we    = (k < 15) ? 2'b11 : 2'b01;
            wa[0] = AW'(2 * k + 1);
            wa[1] = (k < 15) ? AW'(2 * k + 2) : AW'(0);
            wd[0] = 32'h1000 + 32'(k);
            wd[1] = 32'h2000 + 32'(k);
            #1;
            chk($sformatf("drain%0d_count", k), 64'(pending_count), 64'(31 - 2 * k));
            $display("drain step %0d: count=%0d", k, pending_count);
            tick();
        end
        @(negedge clk);
        set_idle();
        ra[0] = 5'd31;
        ra[1] = 5'd30;
        #1;
        chk("drain_final_count", 64'(pending_count), 64'h0);
        chk("drain_x31", 64'(rdata[31:0]), 64'h100F);
        chk("drain_x30", 64'(rdata[63:32]), 64'h200E);
        $display("drain done: count=%0d x31=%h x30=%h", pending_count, rdata[31:0], rdata[63:32]);
        tick();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic narrow;
            @(negedge clk);
            narrow      = 1'($urandom_range(0, 1));
            rst_n       = ($urandom_range(0, 63) != 0);
            we          = 2'($urandom_range(0, 3));
            wa[0]       = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
            wa[1]       = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
            wd[0]       = $urandom;
            wd[1]       = $urandom;
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd    = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
            ra[0]       = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
            ra[1]       = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
            #1;
            chk($sformatf("rnd%0d_rdata0", n), 64'(rdata[31:0]), 64'(exp_rdata(0)));
            chk($sformatf("rnd%0d_rdata1", n), 64'(rdata[63:32]), 64'(exp_rdata(1)));
            chk($sformatf("rnd%0d_rbusy", n), 64'(rbusy), 64'({exp_rbusy(1), exp_rbusy(0)}));
            chk($sformatf("rnd%0d_ready", n), 64'(issue_ready), 64'(exp_ready()));
            chk($sformatf("rnd%0d_count", n), 64'(pending_count), 64'($countones(m_busy)));
            $display("rnd %0d: rst_n=%b we=%b wa=%0d/%0d iv=%b rd=%0d ra=%0d/%0d -> rbusy=%b ready=%b count=%0d",
                     n, rst_n, we, wa[0], wa[1], issue_valid, issue_rd, ra[0], ra[1],
                     rbusy, issue_ready, pending_count);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
